// File: rtl/serial_pkg.sv
// serial_pkg: FSM state encoding and default operand width for serial_subtractor
package serial_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FINISH = 2'd2} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit a - b - bin cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first; SERIAL_SUB_BIN_EN adds a borrow-in port bin
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic brw, bin0, fd, fb, last;
`ifdef SERIAL_SUB_BIN_EN
  assign bin0 = bin;
`else
  assign bin0 = 1'b0;
`endif
  full_subtractor fs (.a(sa[0]), .b(sb[0]), .bin(brw), .diff(fd), .bout(fb));
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    nxt = state == IDLE ? (start ? SHIFT : IDLE) : state == SHIFT ? (last ? FINISH : SHIFT) : IDLE;
    busy = state != IDLE;
    done = state == FINISH;
  end
  // d/bout are only written on the last shift so partial results never show
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      sr <= '0;
      cnt <= '0;
      brw <= 1'b0;
      d <= '0;
      bout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= b;
        cnt <= '0;
        brw <= bin0;
      end else if (state == SHIFT) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        sr <= {fd, sr[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        brw <= fb;
        if (last) begin
          d <= {fd, sr[WIDTH-1:1]};
          bout <= fb;
        end
      end
    end
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 START  input  1  request to begin one subtraction; sampled on each rising edge.
REQ-006 A  input  WIDTH  minuend; sampled only on an accepted START.
REQ-007 B  input  WIDTH  subtrahend; sampled only on an accepted START.
REQ-008 BUSY  output  1  high whenever state is not IDLE.
REQ-009 DONE  output  1  one-cycle pulse marking a valid new result.
REQ-010 D  output  WIDTH  difference A-B, held until the next completion.
REQ-011 BOUT  output  1  final borrow out, held with D.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and FINISH.
REQ-013 In IDLE with START=1, the edge SHALL load A and B into shift registers, clear the bit counter and the borrow flop, and enter SHIFT.
REQ-014 START SHALL be ignored in SHIFT and FINISH, with no effect on operands or result.
REQ-015 Each SHIFT edge SHALL process one bit, LSB first: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-016 Each SHIFT edge SHALL shift d into a result register and store bout in the borrow flop.
REQ-017 The edge processing bit WIDTH-1 SHALL enter FINISH and update D and BOUT with the full result.
REQ-018 FINISH SHALL last exactly one cycle with DONE=1, then return to IDLE.
REQ-019 Latency SHALL be fixed: DONE is high in the cycle after edge k+WIDTH when START is accepted at edge k (WIDTH+1 cycles from START to DONE).
REQ-020 Arithmetic SHALL be modulo 2^WIDTH, with BOUT=1 exactly when A < B (unsigned, borrow-in 0).
REQ-021 D and BOUT SHALL change only on the transition into FINISH or on reset; intermediate bits SHALL never appear on D.
REQ-022 A START asserted in the same cycle that FINISH returns to IDLE SHALL be ignored; it is accepted only when sampled in IDLE.

Reset
REQ-023 While RST=1 at an edge, the next state SHALL be IDLE, and BUSY, DONE, D, BOUT, the counter, the borrow flop and the shift registers SHALL all be 0.
REQ-024 RST SHALL take priority over START and over any in-progress operation.
REQ-025 Reset mid-operation SHALL abort the operation with no DONE pulse; the first START after RST deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_SUB_BIN_EN SHALL control an additional port BIN (input, 1 bit, initial borrow-in for chaining), sampled with A and B on an accepted START and loaded into the borrow flop.
REQ-027 With SERIAL_SUB_BIN_EN defined, the result SHALL be A-B-BIN, with BOUT=1 when A < B+BIN.
REQ-028 Without SERIAL_SUB_BIN_EN, port BIN SHALL not exist and the initial borrow SHALL be 0.

Structure
REQ-029 A shared package serial_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2) and the default WIDTH constant.
REQ-030 The one-bit combinational cell SHALL be a sub-module full_subtractor (outputs difference and borrow; inputs a, b, bin), instantiated once.
REQ-031 The counter width SHALL be the ceiling of log2(WIDTH).

Verification
REQ-032 WIDTH=8, A=0x05, B=0x03, START one cycle: BUSY high for 9 cycles, DONE pulses once 9 cycles after START, D=0x02, BOUT=0.
REQ-033 A=0x03, B=0x05: D=0xFE, BOUT=1; A=0x00, B=0xFF: D=0x01, BOUT=1; A=B=0xAA: D=0x00, BOUT=0.
REQ-034 START with A=0x10, B=0x01, then START with A=0xFF, B=0xFF held high during SHIFT: result D=0x0F, BOUT=0, exactly one DONE pulse.
REQ-035 RST asserted 4 cycles into an operation: next cycle BUSY=0, D=0, BOUT=0, no DONE pulse; a following START with A=0x09, B=0x04 gives D=0x05.
REQ-036 SERIAL_SUB_BIN_EN defined, A=0x05, B=0x03, BIN=1: D=0x01, BOUT=0; A=0x03, B=0x03, BIN=1: D=0xFF, BOUT=1.
REQ-037 Back-to-back operations with START held continuously: one operation accepted every WIDTH+2 cycles, each result correct, D stable between DONE pulses.
